// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO: pointer code conversions and sizing.
package fifo_pkg;

    // Default address width used when a depth constant is needed outside a
    // parameterised module; modules derive their own depth from ASIZE.
    localparam int ASIZE_DEFAULT = 4;
    localparam int FIFO_DEPTH    = 1 << ASIZE_DEFAULT;

    // Widest pointer the helpers handle. Callers zero-extend narrower
    // pointers into this width and truncate the result back. Zero upper bits
    // leave both conversions exact for any narrower width.
    localparam int PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_wide_t;

    // Binary to reflected Gray code.
    function automatic ptr_wide_t bin2gray(input ptr_wide_t b);
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray code to binary: each binary bit is the XOR of all Gray
    // bits at or above it.
    function automatic ptr_wide_t gray2bin(input ptr_wide_t g);
        ptr_wide_t b;
        b = '0;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_sync_r2w.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into this clock.
// The same block serves the read side with the clocks swapped.
module fifo_sync_r2w #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Stage 0 captures the asynchronous input; the last stage is the only
    // one consumed downstream.
    logic [STAGES-1:0][WIDTH-1:0] r_chain;

    // Shift the pointer through the flop chain; reset clears every stage.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_chain <= '0;
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and status stage of the async FIFO. Owns the binary and
// Gray write pointers, drives the RAM write port, and derives full,
// almost-full, occupancy and sticky overflow from the synchronised read
// pointer.
//
// Producer interface: winc is a request, not a valid/ready pair. A write is
// accepted on a rising wclk edge exactly when winc=1 and wfull=0 at that
// edge; wr_en_ram shows that acceptance combinationally. A request while
// wfull=1 is dropped and recorded in woverflow.
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int ASIZE       = 4,
    parameter int AF_THRESH   = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic             wclk,
    input  logic             in_reset,
    input  logic             winc,
    input  logic [ASIZE:0]   rptr_gray,
    output logic             wr_en_ram,
    output logic [ASIZE-1:0] waddr,
    output logic [ASIZE:0]   wptr_gray,
    output logic             wfull,
    output logic             walmost_full,
    output logic [ASIZE:0]   wlevel,
    output logic             woverflow
);

    localparam int PTR_W = ASIZE + 1;
    localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(AF_THRESH);

    // Registered state.
    logic [PTR_W-1:0] r_wbin;
    logic [PTR_W-1:0] r_wptr_gray;
    logic             r_wfull;
    logic             r_walmost_full;
    logic [PTR_W-1:0] r_wlevel;
    logic             r_woverflow;

    // Combinational next-state terms.
    logic [PTR_W-1:0] w_wq_rptr;
    logic [PTR_W-1:0] w_rbin_sync;
    logic             w_push;
    logic [PTR_W-1:0] w_wbin_next;
    logic [PTR_W-1:0] w_wgray_next;
    logic [PTR_W-1:0] w_full_gray;
    logic [PTR_W-1:0] w_level_next;
    logic             w_full_next;
    logic             w_af_next;
    logic             w_ovf_next;

    // Bring the read pointer into wclk through the shared synchroniser.
    fifo_sync_r2w #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_sync_r2w (
        .i_clk   (wclk),
        .i_reset (in_reset),
        .i_d     (rptr_gray),
        .o_q     (w_wq_rptr)
    );

    // Pointer arithmetic and status terms for the coming edge. A write and a
    // read-pointer update seen on the same edge both land in w_level_next.
    always_comb begin
        w_rbin_sync  = PTR_W'(gray2bin(ptr_wide_t'(w_wq_rptr)));
        w_push       = winc & ~r_wfull;
        w_wbin_next  = r_wbin + PTR_W'(w_push);
        w_wgray_next = PTR_W'(bin2gray(ptr_wide_t'(w_wbin_next)));
        // Full when the writer is exactly one lap ahead: in Gray code that is
        // the read pointer with its two top bits inverted.
        w_full_gray  = {~w_wq_rptr[ASIZE:ASIZE-1], w_wq_rptr[ASIZE-2:0]};
        w_full_next  = (w_wgray_next == w_full_gray);
        // The synchronised read pointer lags the true one, so this level can
        // only over-report occupancy, never under-report it.
        w_level_next = w_wbin_next - w_rbin_sync;
        w_af_next    = (w_level_next >= AF_LEVEL);
        w_ovf_next   = r_woverflow | (winc & r_wfull);
    end

    // Pointer registers; wptr_gray comes straight from this flop so nothing
    // combinational sits on the clock-domain crossing.
    always_ff @(posedge wclk) begin
        if (in_reset) begin
            r_wbin      <= '0;
            r_wptr_gray <= '0;
        end else begin
            r_wbin      <= w_wbin_next;
            r_wptr_gray <= w_wgray_next;
        end
    end

    // Status registers: full, almost-full, occupancy and sticky overflow.
    always_ff @(posedge wclk) begin
        if (in_reset) begin
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_wlevel       <= '0;
            r_woverflow    <= 1'b0;
        end else begin
            r_wfull        <= w_full_next;
            r_walmost_full <= w_af_next;
            r_wlevel       <= w_level_next;
            r_woverflow    <= w_ovf_next;
        end
    end

    // The RAM write port follows the accepted request without a register
    // stage so the data written is the data presented with winc.
    assign wr_en_ram    = w_push;
    assign waddr        = r_wbin[ASIZE-1:0];
    assign wptr_gray    = r_wptr_gray;
    assign wfull        = r_wfull;
    assign walmost_full = r_walmost_full;
    assign wlevel       = r_wlevel;
    assign woverflow    = r_woverflow;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full with a per-cycle occupancy model.
module tb_fifo_wptr_full;

    localparam int ASIZE       = 4;
    localparam int AF_THRESH   = 12;
    localparam int SYNC_STAGES = 2;
    localparam int DEPTH       = 1 << ASIZE;

    // ---------------- clock / reset / DUT ----------------
    logic         wclk;
    logic         in_reset;
    logic         winc;
    logic [4:0]   rptr_bin_drv;
    logic [4:0]   rptr_gray;
    logic         wr_en_ram;
    logic [3:0]   waddr;
    logic [4:0]   wptr_gray;
    logic         wfull;
    logic         walmost_full;
    logic [4:0]   wlevel;
    logic         woverflow;

    assign rptr_gray = rptr_bin_drv ^ (rptr_bin_drv >> 1);

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    fifo_wptr_full #(
        .ASIZE       (ASIZE),
        .AF_THRESH   (AF_THRESH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .wclk         (wclk),
        .in_reset     (in_reset),
        .winc         (winc),
        .rptr_gray    (rptr_gray),
        .wr_en_ram    (wr_en_ram),
        .waddr        (waddr),
        .wptr_gray    (wptr_gray),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .woverflow    (woverflow)
    );

    // ---------------- check bookkeeping ----------------
    int n_pass  = 0;
    int n_total = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Counts accepted writes and remembers which read position the write side
    // can currently see (the read pointer from SYNC_STAGES edges ago).
    logic [4:0] m_wr;
    logic [4:0] m_level;
    logic       m_full;
    logic       m_af;
    logic       m_ovf;
    logic [4:0] hist_q[$];

    always @(posedge wclk) begin
        logic [4:0] seen;
        logic       was_full;
        if (in_reset) begin
            m_wr = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0;
            hist_q = {};
            for (int i = 0; i < SYNC_STAGES; i++) hist_q.push_back(5'd0);
        end else begin
            seen     = hist_q.pop_front();
            was_full = m_full;
            if (winc && !was_full) m_wr = m_wr + 5'd1;
            m_level = m_wr - seen;
            m_full  = (m_level == 5'(DEPTH));
            m_af    = (int'(m_level) >= AF_THRESH);
            m_ovf   = m_ovf | (winc & was_full);
            hist_q.push_back(rptr_bin_drv);
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge wclk) begin
        if (chk_en) begin
            chk("cyc_wr_en_ram", wr_en_ram, winc & ~m_full);
            chk("cyc_waddr", waddr, m_wr % DEPTH);
            chk("cyc_wptr_gray", wptr_gray, m_wr ^ (m_wr >> 1));
            chk("cyc_wfull", wfull, m_full);
            chk("cyc_walmost_full", walmost_full, m_af);
            chk("cyc_wlevel", wlevel, m_level);
            chk("cyc_woverflow", woverflow, m_ovf);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [4:0] rb);
        winc = w;
        rptr_bin_drv = rb;
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench did not finish");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int   wraps;
        logic saw31;
        logic saw32;
        logic full_seen;
        logic [3:0] prev_addr;

        in_reset = 1'b1;
        winc = 1'b0;
        rptr_bin_drv = '0;
        tick();
        tick();
        in_reset = 1'b0;
        chk_en = 1'b1;

        // Reset then idle.
        tick();
        chk("rst_wptr_gray", wptr_gray, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wfull", wfull, 0);
        chk("rst_wlevel", wlevel, 0);
        chk("rst_woverflow", woverflow, 0);
        repeat (3) tick();
        chk("idle_wptr_gray", wptr_gray, 0);

        // Fill 16 entries with the reader parked at 0.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 5'd0);
            chk("fill_waddr", waddr, i);
            chk("fill_wr_en", wr_en_ram, 1);
            tick();
            chk("fill_af", walmost_full, (i + 1 >= 12) ? 1 : 0);
        end
        chk("full_wfull", wfull, 1);
        chk("full_wlevel", wlevel, 16);
        chk("full_wptr_gray", wptr_gray, 5'b11000);

        // Overflow: keep requesting while full.
        chk("ovf_wr_en", wr_en_ram, 0);
        chk("ovf_waddr", waddr, 0);
        tick();
        chk("ovf_set", woverflow, 1);
        chk("ovf_wptr_gray", wptr_gray, 5'b11000);
        drive(1'b0, 5'd0);
        tick();
        chk("ovf_sticky", woverflow, 1);

        // Drain visibility: read pointer moves to 4.
        drive(1'b0, 5'd4);
        tick();
        chk("drain_e1_wfull", wfull, 1);
        chk("drain_e1_wlevel", wlevel, 16);
        tick();
        chk("drain_e2_wfull", wfull, 1);
        chk("drain_e2_wlevel", wlevel, 16);
        tick();
        chk("drain_e3_wfull", wfull, 0);
        chk("drain_e3_wlevel", wlevel, 12);
        chk("drain_e3_af", walmost_full, 1);
        drive(1'b0, 5'd5);
        repeat (3) tick();
        chk("drain5_wlevel", wlevel, 11);
        chk("drain5_af", walmost_full, 0);

        // Clear the sticky flag before the wrap run.
        in_reset = 1'b1;
        drive(1'b0, 5'd0);
        tick();
        in_reset = 1'b0;
        chk("rst2_woverflow", woverflow, 0);

        // Wrap: 40 writes with a reader trailing by 3.
        wraps = 0; saw31 = 0; saw32 = 0; full_seen = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, (i >= 3) ? 5'(i - 3) : 5'd0);
            prev_addr = waddr;
            tick();
            if (prev_addr == 4'd15 && waddr == 4'd0) wraps++;
            if (wptr_gray == 5'b10000) saw31 = 1'b1;
            if (saw31 && wptr_gray == 5'b00000) saw32 = 1'b1;
            if (wfull) full_seen = 1'b1;
        end
        drive(1'b0, 5'd37);
        chk("wrap_saw_bin31", saw31, 1);
        chk("wrap_saw_bin32", saw32, 1);
        chk("wrap_waddr_wraps", wraps, 2);
        chk("wrap_never_full", full_seen, 0);
        chk("wrap_woverflow", woverflow, 0);

        // Reset mid-operation after 9 more writes.
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 5'd37);
            tick();
        end
        in_reset = 1'b1;
        drive(1'b0, 5'd0);
        tick();
        in_reset = 1'b0;
        chk("mid_rst_wptr_gray", wptr_gray, 0);
        chk("mid_rst_wlevel", wlevel, 0);
        chk("mid_rst_wfull", wfull, 0);
        chk("mid_rst_woverflow", woverflow, 0);
        drive(1'b1, 5'd0);
        chk("post_rst_waddr", waddr, 0);
        chk("post_rst_wr_en", wr_en_ram, 1);
        tick();
        chk("post_rst_wlevel", wlevel, 1);
        chk("post_rst_wptr_gray", wptr_gray, 5'b00001);
        drive(1'b0, 5'd0);
        repeat (2) tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
